// File: rtl/sram_arbiter_pkg.sv
// Shared types and constants for the Ram2 SRAM arbiter.
// Owner encoding, FSM state type and default strobe timing.
package sram_arbiter_pkg;

    localparam int ADDR_W_DEF    = 18;
    localparam int DATA_W_DEF    = 16;
    localparam int RD_CYCLES_DEF = 2;
    localparam int WR_SETUP_DEF  = 1;
    localparam int WR_PULSE_DEF  = 1;
    localparam int WR_HOLD_DEF   = 1;

    // Wide enough for any sane phase length
    localparam int CNT_W = 8;

    localparam logic OWN_IF  = 1'b0;
    localparam logic OWN_MEM = 1'b1;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_READ   = 3'd1,
        S_WSETUP = 3'd2,
        S_WPULSE = 3'd3,
        S_WHOLD  = 3'd4,
        S_DONE   = 3'd5
    } state_t;

    // Counter value loaded on phase entry; phase ends when it reaches zero
    function automatic logic [CNT_W-1:0] cnt_load(input int cycles);
        return CNT_W'(cycles - 1);
    endfunction

endpackage

// File: rtl/sram_arbiter.sv
// Two-port arbiter for one asynchronous SRAM: IF fetch and MEM load/store.
// Alternating priority, registered strobes, one DONE cycle per transaction.
module sram_arbiter
    import sram_arbiter_pkg::*;
#(
    parameter int ADDR_W    = ADDR_W_DEF,
    parameter int DATA_W    = DATA_W_DEF,
    parameter int RD_CYCLES = RD_CYCLES_DEF,
    parameter int WR_SETUP  = WR_SETUP_DEF,
    parameter int WR_PULSE  = WR_PULSE_DEF,
    parameter int WR_HOLD   = WR_HOLD_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_ready,
    output logic [DATA_W-1:0] if_data,
    output logic              if_stall,
    input  logic              mem_rd,
    input  logic              mem_wr,
    input  logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_wdata,
    output logic              mem_ready,
    output logic [DATA_W-1:0] mem_rdata,
    output logic              mem_stall,
    output logic [ADDR_W-1:0] sram_addr,
    inout  wire  [DATA_W-1:0] sram_data,
    output logic              sram_en,
    output logic              sram_oe,
    output logic              sram_we
);

    state_t             state;
    logic [CNT_W-1:0]   cnt;
    logic               owner;
    logic               last_owner;
    logic               drive;
    logic [DATA_W-1:0]  wdata;
    logic               mem_pend;
    logic               grant_mem;
    logic               grant_if;

    assign mem_pend  = mem_rd | mem_wr;
    // MEM wins unless IF is also waiting and MEM was served last
    assign grant_mem = mem_pend && (!if_req || last_owner == OWN_IF);
    assign grant_if  = if_req && !grant_mem;

    assign if_stall  = if_req && !if_ready;
    assign mem_stall = mem_pend && !mem_ready;

    // Bus is only ever driven during the write phases
    assign sram_data = drive ? wdata : {DATA_W{1'bz}};

    // Transaction sequencer: grant, strobe timing, data capture, ready pulse
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= S_IDLE;
            cnt        <= '0;
            owner      <= OWN_IF;
            last_owner <= OWN_IF;
            drive      <= 1'b0;
            wdata      <= '0;
            sram_addr  <= '0;
            sram_en    <= 1'b1;
            sram_oe    <= 1'b1;
            sram_we    <= 1'b1;
            if_ready   <= 1'b0;
            mem_ready  <= 1'b0;
            if_data    <= '0;
            mem_rdata  <= '0;
        end else begin
            if_ready  <= 1'b0;
            mem_ready <= 1'b0;
            unique case (state)
                S_IDLE: begin
                    if (grant_mem || grant_if) begin
                        owner     <= grant_mem ? OWN_MEM : OWN_IF;
                        sram_addr <= grant_mem ? mem_addr : if_addr;
                        sram_en   <= 1'b0;
                        if (grant_mem && mem_wr) begin
                            wdata <= mem_wdata;
                            drive <= 1'b1;
                            state <= S_WSETUP;
                            cnt   <= cnt_load(WR_SETUP);
                        end else begin
                            sram_oe <= 1'b0;
                            state   <= S_READ;
                            cnt     <= cnt_load(RD_CYCLES);
                        end
                    end
                end
                S_READ: begin
                    if (cnt == '0) begin
                        if (owner == OWN_MEM) begin
                            mem_rdata <= sram_data;
                            mem_ready <= 1'b1;
                        end else begin
                            if_data  <= sram_data;
                            if_ready <= 1'b1;
                        end
                        sram_en <= 1'b1;
                        sram_oe <= 1'b1;
                        state   <= S_DONE;
                        cnt     <= '0;
                    end else begin
                        cnt <= cnt - CNT_W'(1);
                    end
                end
                S_WSETUP: begin
                    if (cnt == '0) begin
                        sram_we <= 1'b0;
                        state   <= S_WPULSE;
                        cnt     <= cnt_load(WR_PULSE);
                    end else begin
                        cnt <= cnt - CNT_W'(1);
                    end
                end
                S_WPULSE: begin
                    if (cnt == '0) begin
                        sram_we <= 1'b1;
                        state   <= S_WHOLD;
                        cnt     <= cnt_load(WR_HOLD);
                    end else begin
                        cnt <= cnt - CNT_W'(1);
                    end
                end
                S_WHOLD: begin
                    if (cnt == '0) begin
                        drive   <= 1'b0;
                        sram_en <= 1'b1;
                        // Only MEM can own a write
                        mem_ready <= 1'b1;
                        state     <= S_DONE;
                        cnt       <= '0;
                    end else begin
                        cnt <= cnt - CNT_W'(1);
                    end
                end
                S_DONE: begin
                    last_owner <= owner;
                    state      <= S_IDLE;
                    cnt        <= '0;
                end
                default: begin
                    state <= S_IDLE;
                    cnt   <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sram_arbiter.sv
// Randomized bench for sram_arbiter with a transaction-timeline model,
// a behavioural SRAM and directed scenarios pinned by literal values.
module tb_sram_arbiter;
    import sram_arbiter_pkg::*;

    localparam int AW = 18;
    localparam int DW = 16;
    localparam int RD = 2;
    localparam int WS = 1;
    localparam int WP = 1;
    localparam int WH = 1;
    localparam int LR = RD;
    localparam int LW = WS + WP + WH;

    logic          clk = 1'b0;
    logic          rst;
    logic          if_req, mem_rd, mem_wr;
    logic [AW-1:0] if_addr, mem_addr;
    logic [DW-1:0] mem_wdata;
    logic          if_ready, if_stall, mem_ready, mem_stall;
    logic [DW-1:0] if_data, mem_rdata;
    logic [AW-1:0] sram_addr;
    logic          sram_en, sram_oe, sram_we;
    tri1  [DW-1:0] sram_data;

    always #5 clk = ~clk;

    sram_arbiter #(
        .ADDR_W(AW), .DATA_W(DW), .RD_CYCLES(RD),
        .WR_SETUP(WS), .WR_PULSE(WP), .WR_HOLD(WH)
    ) dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_ready(if_ready),
        .if_data(if_data), .if_stall(if_stall),
        .mem_rd(mem_rd), .mem_wr(mem_wr), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_ready(mem_ready),
        .mem_rdata(mem_rdata), .mem_stall(mem_stall),
        .sram_addr(sram_addr), .sram_data(sram_data),
        .sram_en(sram_en), .sram_oe(sram_oe), .sram_we(sram_we)
    );

    function automatic logic [11:0] idx(input logic [AW-1:0] a);
        return a[11:0] ^ {6'b0, a[17:12]};
    endfunction

    function automatic logic [DW-1:0] init_word(input logic [11:0] i);
        return (i == 12'h010) ? 16'h4C01 : ({4'h0, i} ^ 16'hA5A5);
    endfunction

    // Behavioural asynchronous SRAM
    logic [DW-1:0] sram_mem  [4096];
    logic [DW-1:0] model_mem [4096];
    assign sram_data = (!sram_en && !sram_oe) ? sram_mem[idx(sram_addr)]
                                              : {DW{1'bz}};
    always @(negedge clk)
        if (!sram_en && !sram_we) sram_mem[idx(sram_addr)] = sram_data;

    // Model state: one transaction timeline
    int            cyc, t0, t_end, free_c, len;
    bit            act, m_own, m_wr, m_last, in_rst;
    logic [AW-1:0] m_addr;
    logic [DW-1:0] m_wdata, e_if_data, e_mem_rdata;
    bit            e_ifr, e_memr;
    int            tests, fails, mode;
    bit            order[$];

    bit            tr_en[4096], tr_oe[4096], tr_we[4096];
    bit            tr_ifr[4096], tr_memr[4096], tr_ifs[4096];
    logic [DW-1:0] tr_bus[4096];

    task automatic chk(input string name, input logic [31:0] a,
                       input logic [31:0] e);
        tests++;
        if (a !== e) begin
            fails++;
            $display("FAIL %s cycle %0d: got %h expected %h", name, cyc, a, e);
        end
    endtask

    function automatic logic [AW-1:0] raddr();
        return AW'($urandom_range(12'h200, 12'hFFF));
    endfunction

    function automatic logic [DW-1:0] rdat();
        return DW'($urandom_range(0, 16'hFFFE));
    endfunction

    task automatic model_reset();
        act = 0; m_last = 0; m_addr = '0;
        e_if_data = '0; e_mem_rdata = '0; e_ifr = 0; e_memr = 0;
    endtask

    // Advance the model across the edge that began cycle cyc
    task automatic model_edge();
        bit gm, gi;
        e_ifr = 0; e_memr = 0;
        if (in_rst) return;
        if (act && cyc > t_end) act = 0;
        if (!act && cyc - 1 >= free_c) begin
            gm = (mem_rd | mem_wr) && (!if_req || m_last == 1'b0);
            gi = if_req && !gm;
            if (gm || gi) begin
                act = 1; t0 = cyc - 1; m_own = gm;
                m_wr = gm && mem_wr;
                m_addr = gm ? mem_addr : if_addr;
                if (m_wr) m_wdata = mem_wdata;
                len = m_wr ? LW : LR;
                t_end = t0 + len + 1;
                free_c = t_end + 1;
            end
        end
        if (act && cyc == t_end) begin
            if (m_wr) model_mem[idx(m_addr)] = m_wdata;
            else if (m_own) e_mem_rdata = model_mem[idx(m_addr)];
            else e_if_data = model_mem[idx(m_addr)];
            if (m_own) e_memr = 1; else e_ifr = 1;
            m_last = m_own;
        end
    endtask

    task automatic check_regs();
        int k;
        bit rdp, wrp, pul;
        k   = act ? cyc - t0 : -1;
        rdp = act && !m_wr && k >= 1 && k <= len;
        wrp = act && m_wr && k >= 1 && k <= len;
        pul = wrp && k >= WS + 1 && k <= WS + WP;
        chk("sram_en", 32'(sram_en), 32'(!(rdp || wrp)));
        chk("sram_oe", 32'(sram_oe), 32'(!rdp));
        chk("sram_we", 32'(sram_we), 32'(!pul));
        chk("sram_addr", 32'(sram_addr), 32'(m_addr));
        chk("if_ready", 32'(if_ready), 32'(e_ifr));
        chk("mem_ready", 32'(mem_ready), 32'(e_memr));
        chk("if_data", 32'(if_data), 32'(e_if_data));
        chk("mem_rdata", 32'(mem_rdata), 32'(e_mem_rdata));
        if (wrp) chk("bus_drive", 32'(sram_data), 32'(m_wdata));
        else if (!rdp) chk("bus_z", 32'(sram_data), 32'h0000FFFF);
        tr_en[cyc & 4095]   = sram_en;
        tr_oe[cyc & 4095]   = sram_oe;
        tr_we[cyc & 4095]   = sram_we;
        tr_ifr[cyc & 4095]  = if_ready;
        tr_memr[cyc & 4095] = mem_ready;
        tr_bus[cyc & 4095]  = sram_data;
    endtask

    task automatic check_stalls();
        chk("if_stall", 32'(if_stall), 32'(if_req && !e_ifr));
        chk("mem_stall", 32'(mem_stall), 32'((mem_rd | mem_wr) && !e_memr));
        tr_ifs[cyc & 4095] = if_stall;
    endtask

    task automatic stim();
        int r;
        case (mode)
            1: begin
                if (if_ready) if_req = 0;
                else if (!if_req && $urandom_range(0, 2) == 0) begin
                    if_req = 1; if_addr = raddr();
                end
                if (mem_ready) begin
                    mem_rd = 0; mem_wr = 0;
                end else if (!(mem_rd | mem_wr) && $urandom_range(0, 2) == 0) begin
                    r = $urandom_range(0, 7);
                    mem_addr = raddr(); mem_wdata = rdat();
                    mem_rd = (r < 4) || (r == 7);
                    mem_wr = (r >= 4);
                end
            end
            2: begin
                if (if_ready) begin if_addr = raddr(); order.push_back(1'b0); end
                if (mem_ready) begin mem_addr = raddr(); order.push_back(1'b1); end
            end
            default: begin
                if (if_ready) if_req = 0;
                if (mem_ready) begin mem_rd = 0; mem_wr = 0; end
            end
        endcase
    endtask

    task automatic step();
        #1;
        check_stalls();
        @(posedge clk);
        #1;
        cyc++;
        model_edge();
        check_regs();
        stim();
    endtask

    task automatic run_until_ready(input bit is_mem, input int budget);
        int n = 0;
        do begin
            step(); n++;
        end while (!(is_mem ? mem_ready : if_ready) && n < budget);
        chk("ready_seen", 32'(is_mem ? mem_ready : if_ready), 32'd1);
    endtask

    task automatic drain();
        int n = 0;
        mode = 0;
        while ((if_req || mem_rd || mem_wr) && n < 30) begin
            step(); n++;
        end
        chk("drained", 32'(if_req || mem_rd || mem_wr), 32'd0);
        step(); step();
    endtask

    task automatic assert_rst();
        #2;
        rst = 1;
        #1;
        in_rst = 1;
        model_reset();
        chk("rst_we", 32'(sram_we), 32'd1);
        chk("rst_en", 32'(sram_en), 32'd1);
        chk("rst_oe", 32'(sram_oe), 32'd1);
        chk("rst_bus", 32'(sram_data), 32'h0000FFFF);
        chk("rst_mem_ready", 32'(mem_ready), 32'd0);
    endtask

    task automatic release_rst();
        #2;
        rst = 0;
        in_rst = 0;
        free_c = cyc;
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int c0;
        for (int i = 0; i < 4096; i++) begin
            sram_mem[i]  = init_word(12'(i));
            model_mem[i] = init_word(12'(i));
        end
        tests = 0; fails = 0; mode = 0; cyc = 0; free_c = 0;
        rst = 1; in_rst = 1;
        if_req = 0; mem_rd = 0; mem_wr = 0;
        if_addr = '0; mem_addr = '0; mem_wdata = '0;
        model_reset();
        step(); step();
        chk("reset_if_data", 32'(if_data), 32'd0);
        chk("reset_mem_rdata", 32'(mem_rdata), 32'd0);
        chk("reset_addr", 32'(sram_addr), 32'd0);
        release_rst();
        step();

        // IF fetch of preloaded word
        c0 = cyc; if_req = 1; if_addr = 18'h00010;
        for (int i = 0; i < 5; i++) step();
        for (int k = 0; k <= 4; k++) begin
            chk("A_en", 32'(tr_en[c0 + k]), 32'(!(k == 1 || k == 2)));
            chk("A_oe", 32'(tr_oe[c0 + k]), 32'(!(k == 1 || k == 2)));
            chk("A_if_ready", 32'(tr_ifr[c0 + k]), 32'(k == 3));
        end
        for (int k = 0; k <= 3; k++)
            chk("A_if_stall", 32'(tr_ifs[c0 + k]), 32'(k <= 2));
        chk("A_if_data", 32'(if_data), 32'h4C01);

        // Store then load back
        c0 = cyc; mem_wr = 1; mem_addr = 18'h08000; mem_wdata = 16'hBEEF;
        for (int i = 0; i < 6; i++) step();
        for (int k = 1; k <= 3; k++)
            chk("B_bus", 32'(tr_bus[c0 + k]), 32'h0000BEEF);
        for (int k = 0; k <= 5; k++) begin
            chk("B_we", 32'(tr_we[c0 + k]), 32'(k != 2));
            chk("B_mem_ready", 32'(tr_memr[c0 + k]), 32'(k == 4));
        end
        mem_rd = 1; mem_addr = 18'h08000;
        run_until_ready(1'b1, 10);
        chk("B_rdata", 32'(mem_rdata), 32'h0000BEEF);
        step();

        // Simultaneous requests right after reset: MEM first
        assert_rst(); step(); release_rst();
        c0 = cyc; if_req = 1; if_addr = 18'h00020;
        mem_rd = 1; mem_addr = 18'h00030;
        for (int i = 0; i < 9; i++) step();
        for (int k = 0; k <= 8; k++) begin
            chk("C_mem_ready", 32'(tr_memr[c0 + k]), 32'(k == 3));
            chk("C_if_ready", 32'(tr_ifr[c0 + k]), 32'(k == 7));
        end

        // Reset during the write pulse
        step();
        c0 = cyc; mem_wr = 1; mem_addr = 18'h00300; mem_wdata = 16'h5A5A;
        step(); step();
        chk("E_we_low", 32'(sram_we), 32'd0);
        assert_rst();
        mem_wr = 0;
        step(); step();
        release_rst();
        step();
        c0 = cyc; mem_rd = 1; mem_addr = 18'h00300;
        for (int i = 0; i < 4; i++) step();
        chk("E_mem_ready", 32'(tr_memr[c0 + 3]), 32'd1);
        chk("E_rdata", 32'(mem_rdata), 32'h0000A6A5);

        // Read and write together act as a write
        step();
        c0 = cyc; mem_rd = 1; mem_wr = 1;
        mem_addr = 18'h00100; mem_wdata = 16'h1234;
        for (int i = 0; i < 6; i++) step();
        chk("F_we", 32'(tr_we[c0 + 2]), 32'd0);
        chk("F_mem_ready", 32'(tr_memr[c0 + 4]), 32'd1);
        mem_rd = 1; mem_addr = 18'h00100;
        run_until_ready(1'b1, 10);
        chk("F_rdata", 32'(mem_rdata), 32'h00001234);
        step();

        // Abandoned load still completes
        c0 = cyc; mem_rd = 1; mem_addr = 18'h00400;
        step(); step();
        mem_rd = 0;
        for (int i = 0; i < 3; i++) step();
        chk("G_mem_ready", 32'(tr_memr[c0 + 3]), 32'd1);
        chk("G_rdata", 32'(mem_rdata), 32'h0000A1A5);

        // Both requesters held continuously: strict alternation
        if_req = 1; if_addr = raddr();
        mem_rd = 1; mem_wr = 0; mem_addr = raddr();
        mode = 2;
        for (int i = 0; i < 40; i++) step();
        drain();
        chk("D_count", 32'(order.size() >= 8), 32'd1);
        for (int i = 1; i < order.size(); i++)
            chk("D_alternate", 32'(order[i] != order[i - 1]), 32'd1);

        // Random traffic
        mode = 1;
        for (int i = 0; i < 2000; i++) step();
        drain();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/sram_arbiter.md
Name: sram_arbiter

Overview:
- Shares one 18-bit-address, 16-bit asynchronous SRAM port (Ram2, program/data) between two requesters: IF-stage instruction fetch (read-only) and MEM-stage load/store (read/write).
- Sequences multi-cycle SRAM read and write strobe timing.
- Returns per-requester ready pulses and stall signals to the pipeline (PC hold, IF/ID, ID/EX).
- Sits between the pipeline stages and the board SRAM pins.

Parameters:
- ADDR_W, 18, SRAM address width
- DATA_W, 16, SRAM data width
- RD_CYCLES, 2, cycles OE/EN held low per read (>=1)
- WR_SETUP, 1, cycles data/addr driven before WE falls (>=1)
- WR_PULSE, 1, cycles WE held low (>=1)
- WR_HOLD, 1, cycles data held after WE rises (>=1)

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous active-high reset
- if_req  in  1  fetch request; held until if_ready
- if_addr  in  ADDR_W  fetch address
- if_ready  out  1  one-cycle pulse; if_data valid
- if_data  out  DATA_W  fetched word, held until next IF completion
- if_stall  out  1  if_req && !if_ready
- mem_rd  in  1  load request; held until mem_ready
- mem_wr  in  1  store request; held until mem_ready
- mem_addr  in  ADDR_W  load/store address
- mem_wdata  in  DATA_W  store data
- mem_ready  out  1  one-cycle completion pulse
- mem_rdata  out  DATA_W  loaded word, held until next MEM read completion
- mem_stall  out  1  (mem_rd|mem_wr) && !mem_ready
- sram_addr  out  ADDR_W  SRAM address
- sram_data  inout  DATA_W  SRAM data; driven only in write states, else Z
- sram_en  out  1  active-low chip enable
- sram_oe  out  1  active-low output enable
- sram_we  out  1  active-low write enable

Behaviour:
- Reset (async, immediate): state IDLE, last_owner=IF, sram_en=sram_oe=sram_we=1, sram_data=Z, sram_addr=0, if_ready=mem_ready=0, if_data=mem_rdata=0.
- States: IDLE, READ, WSETUP, WPULSE, WHOLD, DONE. Down-counter cnt loaded on every state entry.
- IDLE grant, evaluated each cycle:
  - MEM pending = mem_rd|mem_wr.
  - Both MEM and IF pending: grant the requester that is not last_owner.
  - Only one pending: grant it.
  - At the grant edge: latch address (and wdata), set owner; last_owner updates at DONE.
  - mem_rd&&mem_wr together is treated as a write.
- READ: sram_en=0, sram_oe=0, sram_we=1, for RD_CYCLES cycles. On the final cycle's edge, sram_data is latched into if_data or mem_rdata per owner; go to DONE.
- Write path, sram_en=0 and sram_oe=1 throughout, sram_data driven with latched wdata:
  - WSETUP: WR_SETUP cycles, sram_we=1.
  - WPULSE: WR_PULSE cycles, sram_we=0.
  - WHOLD: WR_HOLD cycles, sram_we=1.
  - Then DONE.
- DONE: one cycle. Owner's ready=1, all strobes inactive, no grant. Next state IDLE. Requester drops or changes its request in the cycle after ready, so it cannot be re-granted twice.
- Latency from request cycle 0 (IDLE, port free):
  - read: ready at cycle RD_CYCLES+1
  - write: ready at cycle WR_SETUP+WR_PULSE+WR_HOLD+1
  - port idle one cycle (IDLE) between back-to-back transactions
- sram_addr is registered; stable for the whole transaction including DONE.
- ready outputs are registered. stall outputs are combinational from request and ready.
- Request deasserted mid-transaction: transaction still completes; ready pulses and is ignored.
- Reset mid-transaction: strobes go inactive and bus goes Z asynchronously; no ready is issued for the aborted transaction.
- Address wrap: none; address passes through unmodified.

Decomposition:
- Shared package: state encoding localparams, owner encoding (OWN_IF=0, OWN_MEM=1), default timing constants.
- No sub-module required. The tristate driver is a single continuous assignment, and the counter and FSM stay in one module.

Test Plan:
- Defaults; if_req, if_addr=0x00010, SRAM model returns 0x4C01 -> sram_en/sram_oe low cycles 1-2, if_ready=1 only at cycle 3, if_data=0x4C01, if_stall high cycles 0-2.
- mem_wr, mem_addr=0x08000, mem_wdata=0xBEEF -> data driven cycles 1-3, sram_we low only cycle 2, mem_ready at cycle 4; a following mem_rd at 0x08000 returns mem_rdata=0xBEEF.
- if_req and mem_rd asserted together right after reset -> MEM granted first, mem_ready cycle 3; IF granted cycle 4, if_ready cycle 7.
- if_req and mem_rd held continuously, each re-raised after its ready -> grants strictly alternate MEM, IF, MEM, IF; neither requester waits more than one transaction.
- rst pulsed during WPULSE -> sram_we=1 and sram_data=Z in the same cycle; no mem_ready; FSM in IDLE when rst falls.
- mem_rd=mem_wr=1, mem_wdata=0x1234 at 0x00100 -> write sequence executes (sram_we pulses low); subsequent read returns 0x1234.
